snake_plot_arbiter: RTL and testbench
=====================================

Name: snake_plot_arbiter

Overview:
- Sole owner of the vga_adapter write port (x, y, colour, plot) for the 160x120 snake display.
- Shares that port between three single-pixel requesters: tail-erase (0), head-draw (1) and food-draw (2), using round-robin arbitration.
- Contains a full-screen clear engine that takes exclusive ownership of the port for one complete sweep.
- Sits between the game datapath/control and vga_adapter. All outputs are registered.

Parameters:
- XMAX, 160, horizontal pixel count; clear sweep x range 0..XMAX-1.
- YMAX, 120, vertical pixel count; clear sweep y range 0..YMAX-1.
- CLEAR_COLOUR, 3'b000, colour written during the clear sweep.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- clear_start  in  1  single-cycle pulse; starts a full-screen clear.
- req  in  3  per-requester pixel request; bit i = requester i.
- req_x  in  24  requester i x coordinate at bits [8i+7:8i].
- req_y  in  21  requester i y coordinate at bits [7i+6:7i].
- req_colour  in  9  requester i colour at bits [3i+2:3i].
- gnt  out  3  one-hot grant pulse; the pixel of requester i is on the outputs that cycle.
- x_out  out  8  pixel x to vga_adapter.
- y_out  out  7  pixel y to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  write enable to vga_adapter.
- clear_busy  out  1  high while clear-sweep pixels are being issued.
- clear_done  out  1  one-cycle pulse coincident with the last clear pixel.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, x_out=0, y_out=0, colour=0, plot=0, gnt=0, clear_busy=0, clear_done=0, sweep counters cx=0, cy=0.
- Reset has priority over everything. Reset mid-clear aborts the sweep: no clear_done pulse, return to IDLE.
- States: IDLE and CLEAR.
- IDLE, clear_start=1 at an edge:
  - Same edge registers x_out=0, y_out=0, colour=CLEAR_COLOUR, plot=1, clear_busy=1, gnt=0.
  - Loads cx=1, cy=0 and moves to CLEAR.
  - clear_start beats any pending req in the same cycle; no grant is issued.
- IDLE, no clear_start, at least one eligible req:
  - Requester i is eligible if req[i]=1 and gnt[i]=0 (a requester granted last cycle is masked for one cycle, so it can drop req).
  - Winner = first eligible index scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - Same edge registers gnt=onehot(winner), plot=1, and x_out/y_out/colour from the winner's slices. rr_ptr <= (winner+1) mod 3.
  - Latency: req sampled at edge N; pixel and gnt visible in the cycle after edge N.
- IDLE, nothing eligible: plot=0, gnt=0. x_out/y_out/colour hold their last values.
- Requester contract:
  - Hold req and data stable until gnt[i] is seen high.
  - Deassert req at the edge that samples gnt[i]=1, or keep it high to request another pixel.
  - Data may change only after gnt.
- Throughput: back-to-back grants to different requesters every cycle. Same requester at most every 2nd cycle.
- CLEAR, each edge:
  - Registers plot=1, x_out=cx, y_out=cy, colour=CLEAR_COLOUR, gnt=0.
  - Then cx increments. At cx=XMAX-1, cx wraps to 0 and cy increments.
  - On the edge issuing (XMAX-1, YMAX-1): clear_done=1 for that cycle, clear_busy stays 1 for that cycle, state returns to IDLE, cx/cy reset to 0.
  - Following edge: clear_busy=0, clear_done=0; arbitration resumes in the same edge.
- Clear totals: exactly XMAX*YMAX = 19200 consecutive plot=1 cycles, raster order, no gaps.
- During CLEAR: clear_start is ignored; requests wait with no grants and no lost requests.
- Counter widths: cx 8 bits, cy 7 bits; no overflow beyond XMAX-1/YMAX-1.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles, and again after reset asserted mid-stream. -> plot=0, gnt=3'b000.
- Single req[1]=1 with x=8'd20, y=7'd30, colour=3'b001, dropped after gnt. -> exactly one cycle of gnt=3'b010, plot=1, (20,30,001) one cycle after sampling; rr_ptr=2.
- req=3'b111 held continuously after reset. -> grant sequence 001,010,100,001,... one per cycle, plot=1 every cycle, coordinates matching each slice.
- Only req[0] held high. -> gnt[0] on alternate cycles (1,0,1,0), plot toggling.
- clear_start with req[2] pending in the same cycle. -> no grant; 19200 plot cycles, first (0,0), pixel 160 = (0,1), last (159,119) with clear_done=1. clear_busy high exactly 19200 cycles; gnt=3'b100 in the cycle after the sweep ends.
- Reset asserted after 500 clear pixels. -> plot=0, clear_busy=0, no clear_done. A new clear_start restarts at (0,0).

Source files
------------

// File: rtl/snake_plot_arbiter.sv
// snake_plot_arbiter: owns the vga_adapter write port for the 160x120 snake
// display. Three single-pixel requesters (0 tail-erase, 1 head-draw, 2
// food-draw) share the port round-robin. A clear engine takes the port
// exclusively for one full raster sweep. All outputs are registered.
module snake_plot_arbiter #(
   parameter int         XMAX         = 160,
   parameter int         YMAX         = 120,
   parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_start,
   input  logic [2:0]  req,
   input  logic [23:0] req_x,
   input  logic [20:0] req_y,
   input  logic [8:0]  req_colour,
   output logic [2:0]  gnt,
   output logic [7:0]  x_out,
   output logic [6:0]  y_out,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        clear_busy,
   output logic        clear_done
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [7:0] CX_LAST = 8'(XMAX - 1);
   localparam logic [6:0] CY_LAST = 7'(YMAX - 1);

   state_t     state_reg, state_next;
   logic [1:0] rr_ptr_reg, rr_ptr_next;
   logic [7:0] cx_reg, cx_next;
   logic [6:0] cy_reg, cy_next;

   logic [2:0] gnt_next;
   logic [7:0] x_next;
   logic [6:0] y_next;
   logic [2:0] colour_next;
   logic       plot_next;
   logic       busy_next;
   logic       done_next;

   // A requester granted last cycle is masked so it has time to drop req.
   logic [2:0] eligible;
   assign eligible = req & ~gnt;

   // Per-requester coordinate/colour slices; entry 3 is an unused pad so a
   // 2-bit index can never select outside the array.
   logic [7:0] slice_x      [4];
   logic [6:0] slice_y      [4];
   logic [2:0] slice_colour [4];

   // Scan slot k looks at requester (rr_ptr + k) mod 3.
   logic [1:0] slot_idx [3];
   logic [2:0] slot_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slice
         if (gi < 3) begin : g_real
            assign slice_x[gi]      = req_x[8*gi +: 8];
            assign slice_y[gi]      = req_y[7*gi +: 7];
            assign slice_colour[gi] = req_colour[3*gi +: 3];
         end else begin : g_pad
            assign slice_x[gi]      = '0;
            assign slice_y[gi]      = '0;
            assign slice_colour[gi] = '0;
         end
      end

      for (gi = 0; gi < 3; gi++) begin : g_slot
         logic [2:0] sum;
         assign sum           = {1'b0, rr_ptr_reg} + 3'(gi);
         assign slot_idx[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
         assign slot_hit[gi]  = eligible[slot_idx[gi]];
      end
   endgenerate

   logic       any_hit;
   logic [1:0] win_idx;

   // First eligible requester in rotated priority order.
   always_comb begin
      any_hit = |slot_hit;
      win_idx = slot_idx[2];
      if (slot_hit[0])
         win_idx = slot_idx[0];
      else if (slot_hit[1])
         win_idx = slot_idx[1];
   end

   // Next-state and registered-output decode for the IDLE/CLEAR machine.
   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      cx_next     = cx_reg;
      cy_next     = cy_reg;
      gnt_next    = 3'b000;
      plot_next   = 1'b0;
      x_next      = x_out;
      y_next      = y_out;
      colour_next = colour;
      busy_next   = 1'b0;
      done_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (clear_start) begin
               // First sweep pixel (0,0) goes out on this very edge.
               x_next      = '0;
               y_next      = '0;
               colour_next = CLEAR_COLOUR;
               plot_next   = 1'b1;
               busy_next   = 1'b1;
               cx_next     = 8'd1;
               cy_next     = '0;
               state_next  = CLEAR;
            end else if (any_hit) begin
               gnt_next    = 3'b001 << win_idx;
               plot_next   = 1'b1;
               x_next      = slice_x[win_idx];
               y_next      = slice_y[win_idx];
               colour_next = slice_colour[win_idx];
               rr_ptr_next = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
            end
         end

         CLEAR: begin
            x_next      = cx_reg;
            y_next      = cy_reg;
            colour_next = CLEAR_COLOUR;
            plot_next   = 1'b1;
            busy_next   = 1'b1;
            if (cx_reg == CX_LAST && cy_reg == CY_LAST) begin
               done_next  = 1'b1;
               cx_next    = '0;
               cy_next    = '0;
               state_next = IDLE;
            end else if (cx_reg == CX_LAST) begin
               cx_next = '0;
               cy_next = cy_reg + 7'd1;
            end else begin
               cx_next = cx_reg + 8'd1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // State, pointer, sweep counters and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         cx_reg     <= '0;
         cy_reg     <= '0;
         gnt        <= '0;
         x_out      <= '0;
         y_out      <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         cx_reg     <= cx_next;
         cy_reg     <= cy_next;
         gnt        <= gnt_next;
         x_out      <= x_next;
         y_out      <= y_next;
         colour     <= colour_next;
         plot       <= plot_next;
         clear_busy <= busy_next;
         clear_done <= done_next;
      end
   end

endmodule

// File: tb/tb_snake_plot_arbiter.sv
// Scoreboard bench for snake_plot_arbiter: the driver predicts each cycle's
// outputs from a transaction-level model and queues them; a negedge monitor
// pops and compares against the DUT.
module tb_snake_plot_arbiter;

   localparam int         XMAX = 160;
   localparam int         YMAX = 120;
   localparam logic [2:0] CC   = 3'b000;

   typedef struct packed {
      logic       plot;
      logic [2:0] gnt;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
      logic       busy;
      logic       done;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear_start = 1'b0;
   logic [2:0]  req = '0;
   logic [23:0] req_x = '0;
   logic [20:0] req_y = '0;
   logic [8:0]  req_colour = '0;
   logic [2:0]  gnt;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [2:0]  colour;
   logic        plot;
   logic        clear_busy;
   logic        clear_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   exp_t sb[$];

   // Reference model state (driver process only).
   bit         m_clear;
   int         m_pix;
   int         m_rr;
   logic [2:0] m_gnt;
   logic [7:0] m_x;
   logic [6:0] m_y;
   logic [2:0] m_c;
   logic [2:0] last_gnt;

   snake_plot_arbiter #(.XMAX(XMAX), .YMAX(YMAX), .CLEAR_COLOUR(CC)) dut (
      .clk(clk), .reset(reset), .clear_start(clear_start), .req(req),
      .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .gnt(gnt),
      .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
      .clear_busy(clear_busy), .clear_done(clear_done)
   );

   always #5 clk = ~clk;

   // Predict the outputs of the coming edge, then clock it and queue them.
   task automatic step();
      exp_t e;
      logic [2:0] elig;
      int w;
      e = '0;
      if (reset) begin
         m_clear = 0; m_pix = 0; m_rr = 0;
         m_x = '0; m_y = '0; m_c = '0;
      end else if (m_clear) begin
         e.plot = 1'b1; e.busy = 1'b1; e.colour = CC;
         e.x = 8'(m_pix % XMAX);
         e.y = 7'(m_pix / XMAX);
         e.done = (m_pix == XMAX*YMAX - 1);
         m_pix++;
         if (e.done) begin m_clear = 0; m_pix = 0; end
      end else if (clear_start) begin
         e.plot = 1'b1; e.busy = 1'b1; e.colour = CC;
         m_clear = 1; m_pix = 1;
      end else begin
         elig = req & ~m_gnt;
         w = -1;
         for (int k = 0; k < 3; k++)
            if (w < 0 && elig[(m_rr + k) % 3]) w = (m_rr + k) % 3;
         if (w >= 0) begin
            e.plot   = 1'b1;
            e.gnt    = 3'(1 << w);
            e.x      = req_x[8*w +: 8];
            e.y      = req_y[7*w +: 7];
            e.colour = req_colour[3*w +: 3];
            m_rr     = (w + 1) % 3;
         end else begin
            e.x = m_x; e.y = m_y; e.colour = m_c;
         end
      end
      if (!reset) begin
         m_x = e.x; m_y = e.y; m_c = e.colour;
      end
      m_gnt    = e.gnt;
      last_gnt = e.gnt;
      @(posedge clk);
      sb.push_back(e);
      #1;
   endtask

   task automatic new_data(input int i);
      req_x[8*i +: 8]      = 8'($urandom_range(XMAX-1, 0));
      req_y[7*i +: 7]      = 7'($urandom_range(YMAX-1, 0));
      req_colour[3*i +: 3] = 3'($urandom_range(7, 0));
   endtask

   // Step until requester i is granted, bounded by a cycle budget.
   task automatic wait_gnt(input int i, input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_gnt[i] && n < budget);
      if (!last_gnt[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL grant_timeout req%0d: no grant within %0d cycles, required a grant", i, budget);
      end
   endtask

   // Requesters obeying the contract: hold until granted, then drop or renew.
   task automatic rand_update();
      for (int i = 0; i < 3; i++) begin
         if (req[i] && last_gnt[i]) begin
            if ($urandom_range(1, 0) == 1) new_data(i);
            else req[i] = 1'b0;
         end else if (!req[i]) begin
            if ($urandom_range(1, 0) == 1) begin
               req[i] = 1'b1;
               new_data(i);
            end
         end
      end
   endtask

   // Monitor: compare every queued expectation against the DUT.
   always @(negedge clk) begin : monitor
      exp_t e, g;
      cycle <= cycle + 1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         g.plot = plot; g.gnt = gnt; g.x = x_out; g.y = y_out;
         g.colour = colour; g.busy = clear_busy; g.done = clear_done;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL pixel_check cycle %0d: got plot=%0b gnt=%03b x=%0d y=%0d c=%0d busy=%0b done=%0b, required plot=%0b gnt=%03b x=%0d y=%0d c=%0d busy=%0b done=%0b",
                     cycle, g.plot, g.gnt, g.x, g.y, g.colour, g.busy, g.done,
                     e.plot, e.gnt, e.x, e.y, e.colour, e.busy, e.done);
         end else if (g.gnt != 3'b000) begin
            $display("grant %03b pixel (%0d,%0d) colour %0d", g.gnt, g.x, g.y, g.colour);
         end else if (g.done) begin
            $display("clear sweep complete at cycle %0d", cycle);
         end
      end
   end

   initial begin
      m_gnt = '0; last_gnt = '0;

      // Reset, then quiet idle.
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      repeat (10) step();

      // Single head-draw pixel, dropped after its grant.
      req_x[15:8] = 8'd20; req_y[13:7] = 7'd30; req_colour[5:3] = 3'b001;
      req = 3'b010;
      wait_gnt(1, 5);
      req[1] = 1'b0;
      repeat (2) step();
      // rr_ptr now points at 2, so requester 2 wins over 0.
      new_data(0); new_data(2);
      req = 3'b101;
      step();
      req[2] = 1'b0;
      step();
      req = 3'b000;
      repeat (2) step();

      // All three held continuously after a reset.
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) new_data(i);
      req = 3'b111;
      repeat (12) begin
         step();
         for (int i = 0; i < 3; i++) if (last_gnt[i]) new_data(i);
      end
      req = 3'b000;
      repeat (2) step();

      // Only requester 0 held: granted every other cycle.
      new_data(0);
      req = 3'b001;
      repeat (8) begin
         step();
         if (last_gnt[0]) new_data(0);
      end
      req = 3'b000;
      repeat (2) step();

      // Clear starts with requester 2 pending; stray clear_start ignored.
      new_data(2);
      req = 3'b100;
      clear_start = 1'b1;
      step();
      repeat (100) begin
         clear_start = 1'($urandom_range(1, 0));
         step();
      end
      clear_start = 1'b0;
      wait_gnt(2, XMAX*YMAX);
      req = 3'b000;
      repeat (2) step();

      // Reset 500 pixels into a sweep, then a fresh complete sweep.
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      repeat (499) step();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      repeat (5) step();
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      repeat (XMAX*YMAX + 2) step();

      // Random contract-following traffic.
      repeat (2000) begin
         step();
         rand_update();
      end
      req = 3'b000;
      repeat (3) step();

      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
